// File: rtl/tdc_pulse_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : tdc_pulse_gen_if
// Description : Bundle of the command, TDC stimulus/result and status signals
//               of the TDC start/stop stimulus generator.
// Revision    : 1.0 - initial release
// ============================================================================
interface tdc_pulse_gen_if;
    // Command channel
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_delay;
    logic [7:0] cmd_repeat;

    // Stimulus to the TDC
    logic       start;
    logic       stop;

    // Measurement returned by the TDC
    logic [7:0] counter_data;
    logic       counter_valid;

    // Result and status
    logic [7:0] result_data;
    logic       result_valid;
    logic       result_timeout;
    logic       busy;
    logic       done;

    // Generator side
    modport slave (
        input  cmd_valid,
        input  cmd_delay,
        input  cmd_repeat,
        input  counter_data,
        input  counter_valid,
        output cmd_ready,
        output start,
        output stop,
        output result_data,
        output result_valid,
        output result_timeout,
        output busy,
        output done
    );

    // Controller / TDC side
    modport master (
        output cmd_valid,
        output cmd_delay,
        output cmd_repeat,
        output counter_data,
        output counter_valid,
        input  cmd_ready,
        input  start,
        input  stop,
        input  result_data,
        input  result_valid,
        input  result_timeout,
        input  busy,
        input  done
    );
endinterface
`default_nettype wire

// File: rtl/tdc_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : tdc_pulse_gen
// Description : Programmable start/stop pair generator for TDC self-test.
//               Emits one start/stop pair per repetition with a cycle-exact
//               start-to-stop interval, captures the TDC measurement inside a
//               fixed result window (or reports a timeout) and strobes done
//               after the last pair.
// Revision    : 1.0 - initial release
// ============================================================================
module tdc_pulse_gen #(
    parameter int PULSE_WIDTH = 4,   // start/stop high time in cycles (>=1)
    parameter int TIMEOUT     = 32,  // result window length (>= PULSE_WIDTH)
    parameter int REST        = 8    // quiet cycles between pairs (>=1)
) (
    input  wire logic      clk,
    input  wire logic      rst,
    tdc_pulse_gen_if.slave bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int c_RW = (REST < 2) ? 1 : $clog2(REST + 1);

    localparam logic [c_TW-1:0] c_TIMEOUT = c_TW'(TIMEOUT);
    localparam logic [c_TW-1:0] c_PW_WIN  = c_TW'(PULSE_WIDTH);
    localparam logic [c_RW-1:0] c_REST    = c_RW'(REST);
    localparam logic [8:0]      c_PW      = 9'(PULSE_WIDTH);
    // Smallest interval that still lets start fall before stop rises
    localparam logic [8:0]      c_DMIN    = 9'(PULSE_WIDTH + 1);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_START = 3'd1;
    localparam logic [2:0] c_S_GAP   = 3'd2;
    localparam logic [2:0] c_S_STOP  = 3'd3;
    localparam logic [2:0] c_S_WAIT  = 3'd4;
    localparam logic [2:0] c_S_REST  = 3'd5;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [2:0]      r_state;
    logic [8:0]      r_delay;     // clamped start-rise to stop-rise interval
    logic [7:0]      r_remain;    // pairs still to emit, including current one
    logic [8:0]      r_tcnt;      // cycles since start rose (1 = first high)
    logic [c_TW-1:0] r_wcnt;      // cycles since stop rose (1 = first high)
    logic [c_RW-1:0] r_rcnt;      // cycles spent in REST
    logic            r_win_open;  // result window still accepting a strobe
    logic            r_start;
    logic            r_stop;
    logic            r_done;
    logic            r_cmd_ready;
    logic [7:0]      r_result_data;
    logic            r_result_valid;
    logic            r_result_timeout;

    logic [8:0]      w_delay_cl;
    logic [7:0]      w_repeat_cl;
    logic            w_accept;
    logic            w_stop_rise;
    logic            w_win_close;

    // Clamp the command fields to their usable ranges
    always_comb begin
        w_delay_cl  = {1'b0, bus.cmd_delay};
        w_repeat_cl = bus.cmd_repeat;
        if ({1'b0, bus.cmd_delay} < c_DMIN) begin
            w_delay_cl = c_DMIN;
        end
        if (bus.cmd_repeat == 8'd0) begin
            w_repeat_cl = 8'd1;
        end
    end

    // Ready is only ever raised while idle, so a handshake implies IDLE too
    assign w_accept    = (r_state == c_S_IDLE) & r_cmd_ready & bus.cmd_valid;
    // Edge on which stop is launched and the result window opens
    assign w_stop_rise = (r_state == c_S_GAP) & (r_tcnt == r_delay);
    // Window ends on the first strobe or after its last cycle
    assign w_win_close = r_win_open & (bus.counter_valid | (r_wcnt == c_TIMEOUT));

    // Pair sequencing: start pulse, interval, stop pulse, wait, rest, repeat
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_S_IDLE;
            r_delay  <= c_DMIN;
            r_remain <= 8'd0;
            r_tcnt   <= 9'd0;
            r_rcnt   <= '0;
            r_start  <= 1'b0;
            r_stop   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (w_accept) begin
                        r_delay  <= w_delay_cl;
                        r_remain <= w_repeat_cl;
                        r_tcnt   <= 9'd1;
                        r_start  <= 1'b1;
                        r_state  <= c_S_START;
                    end
                end
                c_S_START: begin
                    r_tcnt <= r_tcnt + 9'd1;
                    if (r_tcnt == c_PW) begin
                        r_start <= 1'b0;
                        r_state <= c_S_GAP;
                    end
                end
                c_S_GAP: begin
                    // D never exceeds 255, so the 9-bit count cannot wrap
                    if (r_tcnt != 9'h1FF) begin
                        r_tcnt <= r_tcnt + 9'd1;
                    end
                    if (w_stop_rise) begin
                        r_stop  <= 1'b1;
                        r_state <= c_S_STOP;
                    end
                end
                c_S_STOP: begin
                    // Window counter also times the stop pulse
                    if (r_wcnt == c_PW_WIN) begin
                        r_stop  <= 1'b0;
                        r_state <= c_S_WAIT;
                    end
                end
                c_S_WAIT: begin
                    if (!r_win_open || w_win_close) begin
                        r_rcnt  <= c_RW'(1);
                        r_state <= c_S_REST;
                    end
                end
                c_S_REST: begin
                    if (r_rcnt == c_REST) begin
                        if (r_remain == 8'd1) begin
                            r_remain <= 8'd0;
                            r_done   <= 1'b1;
                            r_state  <= c_S_IDLE;
                        end else begin
                            r_remain <= r_remain - 8'd1;
                            r_tcnt   <= 9'd1;
                            r_start  <= 1'b1;
                            r_state  <= c_S_START;
                        end
                    end else begin
                        r_rcnt <= r_rcnt + c_RW'(1);
                    end
                end
                default: begin
                    r_start <= 1'b0;
                    r_stop  <= 1'b0;
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    // Result window: capture the first strobe, or report timeout at its end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_open       <= 1'b0;
            r_wcnt           <= '0;
            r_result_data    <= 8'd0;
            r_result_valid   <= 1'b0;
            r_result_timeout <= 1'b0;
        end else begin
            r_result_valid   <= 1'b0;
            r_result_timeout <= 1'b0;

            // Position counter runs through STOP and WAIT and saturates
            if (w_stop_rise) begin
                r_wcnt <= c_TW'(1);
            end else if (((r_state == c_S_STOP) || (r_state == c_S_WAIT)) &&
                         (r_wcnt != c_TIMEOUT)) begin
                r_wcnt <= r_wcnt + c_TW'(1);
            end

            if (w_stop_rise) begin
                r_win_open <= 1'b1;
            end else if (r_win_open) begin
                if (bus.counter_valid) begin
                    r_result_data  <= bus.counter_data;
                    r_result_valid <= 1'b1;
                    r_win_open     <= 1'b0;
                end else if (r_wcnt == c_TIMEOUT) begin
                    r_result_data    <= 8'd0;
                    r_result_timeout <= 1'b1;
                    r_win_open       <= 1'b0;
                end
            end
        end
    end

    // Ready rises one cycle after returning to IDLE and drops on acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd_ready <= 1'b1;
        end else begin
            r_cmd_ready <= (r_state == c_S_IDLE) & ~w_accept;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.cmd_ready      = r_cmd_ready;
    assign bus.start          = r_start;
    assign bus.stop           = r_stop;
    assign bus.result_data    = r_result_data;
    assign bus.result_valid   = r_result_valid;
    assign bus.result_timeout = r_result_timeout;
    assign bus.busy           = (r_state != c_S_IDLE);
    assign bus.done           = r_done;

endmodule
`default_nettype wire

// File: tb/tb_tdc_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdc_pulse_gen
// Description : Scoreboard bench for tdc_pulse_gen. Each command is expanded
//               by a timeline model into expected start/stop rises, results,
//               done and busy/ready windows; a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdc_pulse_gen;

    localparam int PW = 4;
    localparam int TO = 32;
    localparam int RS = 8;

    typedef struct {
        int         c;
        bit         to;
        logic [7:0] d;
    } res_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_tests;
    int   n_fail;

    tdc_pulse_gen_if bus ();

    tdc_pulse_gen #(
        .PULSE_WIDTH(PW),
        .TIMEOUT    (TO),
        .REST       (RS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Expected events, keyed by the cycle in which they must be visible
    int         q_start[$];
    int         q_stop[$];
    res_t       q_res[$];
    int         q_done[$];
    int         busy_lo, busy_hi;   // busy expected high in [lo,hi]
    int         rdy_lo,  rdy_hi;    // cmd_ready expected low in [lo,hi]
    logic [7:0] hold_d;             // value result_data must hold
    bit         cv_at[int];         // TDC strobe schedule
    logic [7:0] cd_at[int];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp, input int c);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, c);
        end
    endtask

    task automatic flag(input string nm, input int c);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event with nothing expected (cycle %0d)", nm, c);
    endtask

    // TDC model: plays back the strobe schedule
    initial begin
        bus.counter_valid = 1'b0;
        bus.counter_data  = 8'd0;
        forever begin
            @(posedge clk);
            #1;
            bus.counter_valid = (cv_at.exists(cyc + 1) != 0);
            bus.counter_data  = (cd_at.exists(cyc + 1) != 0) ? cd_at[cyc + 1]
                                                               : 8'($urandom);
        end
    end

    // Monitor: compares every DUT output event against the scoreboard
    initial begin
        logic p_start, p_stop;
        int   s_rise, t_rise, c;
        res_t e;
        p_start = 1'b0;
        p_stop  = 1'b0;
        s_rise  = 0;
        t_rise  = 0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            c = cyc + 1;
            if (bus.start && !p_start) begin
                s_rise = c;
                if (q_start.size() == 0) flag("start_rise", c);
                else check("start_rise", c, q_start.pop_front(), c);
            end
            if (!bus.start && p_start) check("start_width", c - s_rise, PW, c);
            if (bus.stop && !p_stop) begin
                t_rise = c;
                if (q_stop.size() == 0) flag("stop_rise", c);
                else check("stop_rise", c, q_stop.pop_front(), c);
            end
            if (!bus.stop && p_stop) check("stop_width", c - t_rise, PW, c);
            check("start_stop_overlap", bus.start & bus.stop, 0, c);
            if (bus.result_valid || bus.result_timeout) begin
                if (q_res.size() == 0) flag("result", c);
                else begin
                    e = q_res.pop_front();
                    check("result_cycle", c, e.c, c);
                    check("result_valid", bus.result_valid, !e.to, c);
                    check("result_timeout", bus.result_timeout, e.to, c);
                    check("result_data", bus.result_data, e.d, c);
                    hold_d = e.d;
                end
            end else begin
                check("result_hold", bus.result_data, hold_d, c);
            end
            if (bus.done) begin
                if (q_done.size() == 0) flag("done", c);
                else check("done_cycle", c, q_done.pop_front(), c);
            end
            check("busy", bus.busy, (c >= busy_lo && c <= busy_hi), c);
            check("cmd_ready", bus.cmd_ready, !(c >= rdy_lo && c <= rdy_hi), c);
            p_start = bus.start;
            p_stop  = bus.stop;
        end
    end

    // Drop every expectation later than the reset edge rc
    task automatic purge(input int rc);
        for (int i = q_start.size() - 1; i >= 0; i--) if (q_start[i] > rc) q_start.delete(i);
        for (int i = q_stop.size() - 1; i >= 0; i--)  if (q_stop[i] > rc)  q_stop.delete(i);
        for (int i = q_res.size() - 1; i >= 0; i--)   if (q_res[i].c > rc) q_res.delete(i);
        for (int i = q_done.size() - 1; i >= 0; i--)  if (q_done[i] > rc)  q_done.delete(i);
        cv_at.delete();
        cd_at.delete();
        busy_hi = rc;
        rdy_hi  = rc;
        hold_d  = 8'd0;
    endtask

    // Issue one command and build its expected timeline.
    // kfix: <0 random response per pair, 0 silent TDC, >0 strobe k cycles into window.
    task automatic issue(input logic [7:0] dly, input logic [7:0] rpt, input int kfix,
                         input bit spur, input bit busy_cmd, input bit do_rst);
        int   d, r, t, t0, k, e, x, done_c, rc, sc;
        res_t rr;
        repeat (int'($urandom_range(2, 5))) begin @(posedge clk); #1; end
        bus.cmd_delay  = dly;
        bus.cmd_repeat = rpt;
        bus.cmd_valid  = 1'b1;
        t0 = cyc + 1;
        d  = (int'(dly) < PW + 1) ? PW + 1 : int'(dly);
        r  = (rpt == 8'd0) ? 1 : int'(rpt);
        t  = t0;
        for (int p = 0; p < r; p++) begin
            q_start.push_back(t + 1);
            q_stop.push_back(t + d + 1);
            if (spur) begin
                sc = int'($urandom_range(t + d, t + 1));
                cv_at[sc] = 1'b1;
            end
            if (kfix < 0) k = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, TO));
            else          k = kfix;
            if (k > 0) begin
                e = t + d + k;
                cv_at[e] = 1'b1;
                cd_at[e] = 8'($urandom);
                rr.c = e + 1; rr.to = 1'b0; rr.d = cd_at[e];
                if (spur) begin
                    sc = e + int'($urandom_range(1, 3));
                    cv_at[sc] = 1'b1;
                    cd_at[sc] = 8'($urandom);
                end
            end else begin
                e = t + d + TO;
                rr.c = e + 1; rr.to = 1'b1; rr.d = 8'd0;
            end
            q_res.push_back(rr);
            x = (e > t + d + PW + 1) ? e : t + d + PW + 1;
            t = x + RS;
        end
        done_c = t + 1;
        q_done.push_back(done_c);
        busy_lo = t0 + 1;
        busy_hi = done_c - 1;
        rdy_lo  = t0 + 1;
        rdy_hi  = done_c;
        @(posedge clk); #1;
        bus.cmd_valid  = 1'b0;
        bus.cmd_delay  = 8'($urandom);
        bus.cmd_repeat = 8'($urandom);
        if (busy_cmd) begin
            @(posedge clk); #1;
            bus.cmd_valid  = 1'b1;
            bus.cmd_delay  = 8'd3;
            bus.cmd_repeat = 8'd2;
            repeat (4) begin @(posedge clk); #1; end
            bus.cmd_valid = 1'b0;
        end
        if (do_rst) begin
            rc = t0 + PW + 2;
            while (cyc < rc - 1) begin @(posedge clk); #1; end
            rst = 1'b1;
            @(posedge clk); #1;
            purge(rc);
            rst = 1'b0;
            @(negedge clk);
            check("rst_start", bus.start, 0, cyc + 1);
            check("rst_stop", bus.stop, 0, cyc + 1);
            check("rst_result_valid", bus.result_valid, 0, cyc + 1);
            check("rst_result_timeout", bus.result_timeout, 0, cyc + 1);
            check("rst_result_data", bus.result_data, 0, cyc + 1);
            check("rst_done", bus.done, 0, cyc + 1);
            check("rst_busy", bus.busy, 0, cyc + 1);
            check("rst_cmd_ready", bus.cmd_ready, 1, cyc + 1);
            @(posedge clk); #1;
        end else begin
            while (cyc < done_c + 1) begin @(posedge clk); #1; end
        end
        check("pending_events", q_start.size() + q_stop.size() + q_res.size() + q_done.size(),
              0, cyc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        busy_lo = 1; busy_hi = 0;
        rdy_lo  = 1; rdy_hi  = 0;
        hold_d  = 8'd0;
        rst            = 1'b1;
        bus.cmd_valid  = 1'b0;
        bus.cmd_delay  = 8'd0;
        bus.cmd_repeat = 8'd0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("init_start", bus.start, 0, cyc);
        check("init_stop", bus.stop, 0, cyc);
        check("init_busy", bus.busy, 0, cyc);
        check("init_cmd_ready", bus.cmd_ready, 1, cyc);
        check("init_done", bus.done, 0, cyc);
        check("init_result_valid", bus.result_valid, 0, cyc);
        check("init_result_timeout", bus.result_timeout, 0, cyc);
        check("init_result_data", bus.result_data, 0, cyc);
        @(posedge clk); #1;
        rst = 1'b0;

        issue(8'd10, 8'd1, 3 + 1, 1'b0, 1'b0, 1'b0);  // nominal: 0x?? at stop+3
        issue(8'd2,  8'd1, 3,     1'b0, 1'b0, 1'b0);  // clamp to PW+1
        issue(8'd10, 8'd1, 0,     1'b0, 1'b0, 1'b0);  // silent TDC -> timeout
        issue(8'd10, 8'd3, 5,     1'b0, 1'b0, 1'b0);  // three pairs
        issue(8'd7,  8'd0, 6,     1'b0, 1'b0, 1'b0);  // repeat 0 -> one pair
        issue(8'd12, 8'd2, 5,     1'b1, 1'b1, 1'b0);  // spurious strobes, busy cmd
        issue(8'd20, 8'd1, 5,     1'b0, 1'b0, 1'b1);  // reset mid-GAP
        issue(8'd10, 8'd1, 4,     1'b0, 1'b0, 1'b0);  // accepted after reset
        issue(8'd255, 8'd1, TO,   1'b1, 1'b0, 1'b0);  // max interval, last window cycle
        issue(8'd0,  8'd1, 1,     1'b0, 1'b0, 1'b0);  // first window cycle
        issue(8'd9,  8'd2, 1,     1'b1, 1'b0, 1'b0);  // result during STOP
        for (int n = 0; n < 25; n++) begin
            issue(8'($urandom_range(0, 60)), 8'($urandom_range(0, 4)), -1,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tdc_pulse_gen.md
# tdc_pulse_gen

Programmable start/stop stimulus generator that drives the TDC's `start` and `stop` inputs with a clock-accurate interval, then collects the TDC's `counter_data`/`counter_valid` result. It sits beside the TDC in the calibration/self-test path. A command sets the interval and the repetition count. The block emits one start/stop pair per repetition, returns one result or timeout per pair, and signals completion.

## Interface
- `PULSE_WIDTH`, default 4: high time of `start` and of `stop`, in `clk` cycles (≥1).
- `TIMEOUT`, default 32: length in cycles of the result window; must be ≥ `PULSE_WIDTH`.
- `REST`, default 8: cycles with both `start` and `stop` low between consecutive pairs (≥1).
- `clk` in 1: sole clock. All logic is clocked on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_delay` in 8: start-rise to stop-rise interval, in cycles.
- `cmd_repeat` in 8: number of pairs; 0 is treated as 1.
- `start` out 1: to TDC `start`; registered.
- `stop` out 1: to TDC `stop`; registered.
- `counter_data` in 8: from TDC.
- `counter_valid` in 1: from TDC, one-cycle strobe.
- `result_data` out 8: captured measurement; 0 on timeout.
- `result_valid` out 1: one-cycle strobe per captured measurement.
- `result_timeout` out 1: one-cycle strobe when a window expires without a result.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle strobe after the last pair of a command completes.

## Operation
- **Command acceptance:** a command is accepted on an edge where `cmd_valid & cmd_ready`. The block latches:
  - D = max(`cmd_delay`, `PULSE_WIDTH`+1). The clamp guarantees `start` falls before `stop` rises.
  - R = max(`cmd_repeat`, 1).
- **States:** IDLE → START → GAP → STOP → WAIT → REST → (START | IDLE).
  - IDLE: `start`=`stop`=0. Goes to START on command acceptance.
  - START: `start`=1 for `PULSE_WIDTH` cycles, then GAP.
  - GAP: both low until D cycles have elapsed since `start` rose, then STOP.
  - STOP: `stop`=1 for `PULSE_WIDTH` cycles, then WAIT.
  - WAIT: both low until the window closes.
  - REST: both low for `REST` cycles. Then decrement the remaining count. Go to START if it is nonzero; otherwise assert `done` and go to IDLE.
- **Result window:** opens on the first cycle `stop` is high and lasts exactly `TIMEOUT` cycles, spanning STOP and WAIT.
  - The first `counter_valid` in the window loads `counter_data` into `result_data` and pulses `result_valid` on the next cycle. The window then closes immediately; WAIT exits once STOP has also finished.
  - If no strobe arrives, `result_timeout` pulses on the cycle after the window's last cycle, with `result_data`=0.
  - `counter_valid` outside a window, or a second strobe in the same window, is ignored.
- **Outputs:** `result_data` holds its value until the next result or timeout. Exactly one of `result_valid`/`result_timeout` is produced per pair.
- **Cycle counters:** saturate or are sized to avoid wrap. The interval counter is 9 bits so D=255 is reachable.
- **Busy behaviour:** `cmd_valid` while busy is ignored; no queuing.
- **Reset values:** `start`, `stop`, `result_valid`, `result_timeout`, `done`, `busy` = 0; `result_data` = 0; `cmd_ready` = 1; state = IDLE. Reset mid-operation forces these values on the next edge and abandons the command with no `done`.

## Timing
- Let T0 be the accept edge.
- `start` is high for cycles T0+1 … T0+`PULSE_WIDTH`.
- `stop` is high for cycles T0+1+D … T0+D+`PULSE_WIDTH`.
- Window covers cycles T0+1+D … T0+D+`TIMEOUT`.
- `counter_valid` sampled at cycle C → `result_valid` and `result_data` at C+1.
- Timeout strobe at T0+D+`TIMEOUT`+1.
- The next pair's `start` rises `REST`+1 cycles after the cycle WAIT exits.
- `done` coincides with the return to IDLE. `cmd_ready` rises the following cycle.

## Test plan
- **Single pair, nominal:** PW=4, TIMEOUT=32, cmd_delay=10, repeat=1. The TDC model returns 0x2A three cycles after `stop` rises.
  - Required: `start` high T0+1..T0+4; `stop` high T0+11..T0+14.
  - Required: `result_valid` with 0x2A at T0+15; `done` once; no `result_timeout`.
- **Clamp:** cmd_delay=2 with PW=4. Required: `stop` rises at T0+6, and `start` has been low at T0+5.
- **Timeout:** cmd_delay=10, TDC silent. Required: `result_timeout`=1 and `result_data`=0 at T0+43; `result_valid` never asserted; `done` asserted.
- **Repeat:** cmd_repeat=3 (also cmd_repeat=0, which must yield 1 pair).
  - Required: exactly 3 start/stop pairs, each separated by ≥ `REST` low cycles.
  - Required: 3 `result_valid` strobes, then a single `done`.
- **Spurious and busy inputs:** `counter_valid` pulsed during GAP, plus a second strobe in the same window, plus `cmd_valid` while busy. Required: the GAP strobe and second strobe are ignored, `cmd_ready`=0 while busy, and the second command is not executed.
- **Reset mid-GAP:** assert `rst` for 1 cycle. Required: all outputs return to reset values on the next edge, no `done`, and a new command is accepted normally afterwards.
